// File: rtl/bitboard_enumerator.sv
// Bitboard enumerator: streams the square index of every set bit,
// lowest first, one per accepted beat; an empty board yields one pass beat.
module bitboard_enumerator #(
  parameter int WIDTH = 64,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_pass,
  output logic             out_last,
  output logic [CNT_W-1:0] out_seq,
  output logic [CNT_W-1:0] out_total
);

  localparam int SW = (WIDTH < 8) ? WIDTH : 8;
  localparam int NS = WIDTH / SW;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   rem_q;
  logic [CNT_W-1:0]   seq_q;
  logic [CNT_W-1:0]   total_q;
  logic               pass_q;
  logic [IDX_W-1:0]   idx;
  logic               single;
  logic               emit;
  logic               in_fire;
  logic               out_fire;

  // Per-slice bit counts summed into the full popcount.
  function automatic logic [CNT_W-1:0] popcount(
    input logic [WIDTH-1:0] b
  );
    logic [CNT_W-1:0] sum;
    logic [3:0]       s;
    sum = '0;
    for (int j = 0; j < NS; j++) begin
      s = '0;
      for (int i = 0; i < SW; i++)
        s = s + 4'(b[j*SW+i]);
      sum = sum + CNT_W'(s);
    end
    return sum;
  endfunction

  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (rem_q[i]) idx = IDX_W'(i);
  end

  assign single   = (rem_q & (rem_q - WIDTH'(1))) == '0;
  assign emit     = (state_q == EMIT);
  assign in_ready = ~reset & (~emit | (out_ready & single));
  assign in_fire  = in_valid & in_ready;
  assign out_fire = emit & out_ready;

  assign out_valid = emit;
  assign out_last  = emit & single;
  assign out_pass  = emit & pass_q;
  assign out_index = idx;
  assign out_seq   = seq_q;
  assign out_total = total_q;

  always_comb begin
    state_d = state_q;
    if (in_fire)
      state_d = EMIT;
    else if (out_fire && single)
      state_d = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q   <= '0;
      seq_q   <= '0;
      total_q <= '0;
      pass_q  <= 1'b0;
    end else if (in_fire) begin
      rem_q   <= in_bits;
      seq_q   <= '0;
      total_q <= popcount(in_bits);
      pass_q  <= (in_bits == '0);
    end else if (out_fire) begin
      rem_q   <= rem_q & (rem_q - WIDTH'(1));
      seq_q   <= seq_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bitboard_enumerator.sv
// Directed vectors and multi-cycle sequences for bitboard_enumerator.
module tb_bitboard_enumerator;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_bits;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_index;
  logic        out_pass;
  logic        out_last;
  logic [6:0]  out_seq;
  logic [6:0]  out_total;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  bitboard_enumerator dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bits   (in_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_pass  (out_pass),
    .out_last  (out_last),
    .out_seq   (out_seq),
    .out_total (out_total)
  );

  typedef struct {
    logic [63:0] bits;
    bit          first;
    logic [5:0]  idx;
    logic [6:0]  seq;
    bit          last;
    bit          pass;
    logic [6:0]  total;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // All tasks start and end at a negedge.
  task automatic send(input logic [63:0] b);
    int n;
    in_valid = 1'b1;
    in_bits  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock);
    chk("first_beat_latency", 32'(out_valid), 32'd1);
  endtask

  task automatic beat(input string name, input logic [5:0] idx,
                      input logic [6:0] seq, input bit last,
                      input bit pass, input logic [6:0] total);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_fields"},
        {4'(out_valid), 2'b0, out_index, 1'b0, out_seq,
         3'b0, out_last, 3'b0, out_pass, 1'b0, out_total},
        {4'd1, 2'b0, idx, 1'b0, seq,
         3'b0, last, 3'b0, pass, 1'b0, total});
    chk({name, "_ready_stalled"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1 chk({name, "_ready_accept"}, 32'(in_ready), 32'(last));
    @(posedge clock);
    #1 out_ready = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int k;
    int cyc;
    bit r;
    bit v;
    vecs[0] = '{64'h1, 1, 6'd0, 7'd0, 1, 0, 7'd1};
    vecs[1] = '{64'h8000_0000_0000_0011, 1, 6'd0, 7'd0, 0, 0, 7'd3};
    vecs[2] = '{64'h0, 0, 6'd4, 7'd1, 0, 0, 7'd3};
    vecs[3] = '{64'h0, 0, 6'd63, 7'd2, 1, 0, 7'd3};
    vecs[4] = '{64'h0, 1, 6'd0, 7'd0, 1, 1, 7'd0};
    vecs[5] = '{64'h8000_0000_0000_0000, 1, 6'd63, 7'd0, 1, 0, 7'd1};
    vecs[6] = '{64'hA0, 1, 6'd5, 7'd0, 0, 0, 7'd2};
    vecs[7] = '{64'h0, 0, 6'd7, 7'd1, 1, 0, 7'd2};
    vecs[8] = '{64'h0010_0000_0000_0000, 1, 6'd52, 7'd0, 1, 0, 7'd1};
    vecs[9] = '{64'h0, 1, 6'd0, 7'd0, 1, 1, 7'd0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_bits   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_outputs",
        {out_valid, out_last, out_pass, out_index, out_seq, out_total},
        '0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1 chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].first) send(vecs[i].bits);
      beat($sformatf("vec%0d", i), vecs[i].idx, vecs[i].seq,
           vecs[i].last, vecs[i].pass, vecs[i].total);
    end
    chk("idle_after_table", 32'(out_valid), 32'd0);

    // All ones with a randomly stalling consumer.
    send('1);
    k = 0;
    cyc = 0;
    while (k < 64 && cyc < 1000) begin
      v = out_valid;
      if (v)
        chk("ones_beat",
            {out_index, 1'b0, out_seq, out_last, 7'b0, out_total},
            {k[5:0], 1'b0, 7'(k), (k == 63), 7'b0, 7'd64});
      r = 1'($urandom_range(0, 1));
      out_ready = r;
      @(posedge clock);
      #1 if (v && r) k++;
      @(negedge clock);
      cyc++;
    end
    out_ready = 1'b0;
    chk("ones_count", 32'(k), 32'd64);
    chk("ones_done", 32'(out_valid), 32'd0);

    // Back-to-back: next board offered during the last beat.
    send(64'h3);
    beat("b2b_a0", 6'd0, 7'd0, 0, 0, 7'd2);
    chk("b2b_a1", {out_valid, out_index, out_last},
        {1'b1, 6'd1, 1'b1});
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bits   = 64'h300;
    #1 chk("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1 begin
      out_ready = 1'b0;
      in_valid  = 1'b0;
    end
    @(negedge clock);
    chk("b2b_no_bubble",
        {out_valid, out_index, out_seq, out_last, out_total},
        {1'b1, 6'd8, 7'd0, 1'b0, 7'd2});
    beat("b2b_b0", 6'd8, 7'd0, 0, 0, 7'd2);
    beat("b2b_b1", 6'd9, 7'd1, 1, 0, 7'd2);

    // Reset in the middle of a board.
    send(64'h1F);
    beat("rst_b0", 6'd0, 7'd0, 0, 0, 7'd5);
    beat("rst_b1", 6'd1, 7'd1, 0, 0, 7'd5);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1 chk("rst_release_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    chk("rst_no_beats", 32'(out_valid), 32'd0);
    send(64'h6);
    beat("rst_n0", 6'd1, 7'd0, 0, 0, 7'd2);
    beat("rst_n1", 6'd2, 7'd1, 1, 0, 7'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
